// File: rtl/connect4_pkg.sv
// Shared encodings for the 4x4 Connect4 game: game states, winner codes,
// turn phases, board size and player encoding.
package connect4_pkg;

  localparam int CELLS_NUMBER = 16;
  localparam int MOVE_COUNT_W = 5;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  typedef enum logic [1:0] {
    GAME_INIT = 2'b00,
    P1_TURN   = 2'b01,
    P2_TURN   = 2'b10,
    END_GAME  = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    WINNER_NONE = 2'b00,
    WINNER_P1   = 2'b01,
    WINNER_P2   = 2'b10,
    WINNER_DRAW = 2'b11
  } winner_e;

  typedef enum logic [1:0] {
    WAIT_MOVE  = 2'b00,
    WAIT_DROP  = 2'b01,
    WAIT_CHECK = 2'b10
  } turn_phase_e;

  function automatic game_state_e other_turn(input game_state_e s);
    return (s == P1_TURN) ? P2_TURN : P1_TURN;
  endfunction

  function automatic winner_e winner_for(input logic player);
    return (player == PLAYER_2) ? WINNER_P2 : WINNER_P1;
  endfunction

  // Saturating increment: the count never passes the board size.
  function automatic logic [MOVE_COUNT_W-1:0] move_count_inc(
      input logic [MOVE_COUNT_W-1:0] cnt,
      input logic [MOVE_COUNT_W-1:0] limit);
    return (cnt >= limit) ? cnt : cnt + MOVE_COUNT_W'(1);
  endfunction

endpackage

// File: rtl/turn_controller_if.sv
// Player request, board drop and win-check handshakes plus game status.
// The controller uses the master modport; the surrounding system uses slave.
interface turn_controller_if;

  logic       start;
  logic       p1_valid;
  logic [1:0] p1_column;
  logic       p2_valid;
  logic [1:0] p2_column;

  logic       drop_req;
  logic [1:0] drop_column;
  logic       drop_player;
  logic       drop_ack;
  logic       drop_invalid;

  logic       check_req;
  logic       check_done;
  logic       check_win;

  logic [1:0] state;
  logic [1:0] winner;
  logic [4:0] move_count;
  logic       invalid_move;
  logic       turn_timeout;

  modport master (
    input  start, p1_valid, p1_column, p2_valid, p2_column,
    input  drop_ack, drop_invalid, check_done, check_win,
    output drop_req, drop_column, drop_player, check_req,
    output state, winner, move_count, invalid_move, turn_timeout
  );

  modport slave (
    output start, p1_valid, p1_column, p2_valid, p2_column,
    output drop_ack, drop_invalid, check_done, check_win,
    input  drop_req, drop_column, drop_player, check_req,
    input  state, winner, move_count, invalid_move, turn_timeout
  );

endinterface

// File: rtl/turn_timer.sv
// Per-turn timeout: loadable down-counter that flags expiry when it is
// enabled while already at zero.
module turn_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load wins over clear so a turn can start in the same cycle idle ends.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_VAL;
    end else if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = en_i && (count_q == '0);

endmodule

// File: rtl/turn_controller.sv
// Connect4 game sequencer: arbitrates player requests, drives the board drop
// and win-check handshakes, counts moves and enforces the per-turn timeout.
module turn_controller #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CELLS_NUMBER   = connect4_pkg::CELLS_NUMBER
) (
  input  logic              clk,
  input  logic              reset,
  turn_controller_if.master bus
);

  import connect4_pkg::*;

  localparam logic [MOVE_COUNT_W-1:0] CELLS_LIMIT = MOVE_COUNT_W'(CELLS_NUMBER);

  game_state_e              state_q, state_d;
  turn_phase_e              phase_q, phase_d;
  winner_e                  winner_q, winner_d;
  logic [MOVE_COUNT_W-1:0]  move_count_q, move_count_d;
  logic [1:0]               column_q, column_d;
  logic                     player_q, player_d;
  logic                     drop_req_q, drop_req_d;
  logic                     check_req_q, check_req_d;
  logic                     invalid_move_q, invalid_move_d;
  logic                     turn_timeout_q, turn_timeout_d;

  logic                     in_turn;
  logic                     cur_player;
  logic                     req_valid;
  logic [1:0]               req_column;
  logic                     timer_clear;
  logic                     timer_load;
  logic                     timer_en;
  logic                     timer_expire;

  // Only the player whose turn it is can be heard; the other side is masked.
  assign in_turn    = (state_q == P1_TURN) || (state_q == P2_TURN);
  assign cur_player = (state_q == P2_TURN) ? PLAYER_2 : PLAYER_1;
  assign req_valid  = (cur_player == PLAYER_2) ? bus.p2_valid  : bus.p1_valid;
  assign req_column = (cur_player == PLAYER_2) ? bus.p2_column : bus.p1_column;

  assign timer_clear = !in_turn;
  assign timer_en    = in_turn && (phase_q == WAIT_MOVE) && !req_valid;

  turn_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_turn_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (timer_clear),
    .load_i   (timer_load),
    .en_i     (timer_en),
    .expire_o (timer_expire)
  );

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    winner_d       = winner_q;
    move_count_d   = move_count_q;
    column_d       = column_q;
    player_d       = player_q;
    drop_req_d     = drop_req_q;
    check_req_d    = check_req_q;
    invalid_move_d = 1'b0;
    turn_timeout_d = 1'b0;
    timer_load     = 1'b0;

    case (state_q)
      GAME_INIT: begin
        move_count_d = '0;
        winner_d     = WINNER_NONE;
        phase_d      = WAIT_MOVE;
        if (bus.start) begin
          state_d    = P1_TURN;
          timer_load = 1'b1;
        end
      end

      // Results stay visible until start returns the game to GAME_INIT.
      END_GAME: begin
        phase_d = WAIT_MOVE;
        if (bus.start) begin
          state_d      = GAME_INIT;
          move_count_d = '0;
          winner_d     = WINNER_NONE;
        end
      end

      P1_TURN, P2_TURN: begin
        case (phase_q)
          WAIT_MOVE: begin
            if (req_valid) begin
              column_d   = req_column;
              player_d   = cur_player;
              drop_req_d = 1'b1;
              phase_d    = WAIT_DROP;
            end else if (timer_expire) begin
              turn_timeout_d = 1'b1;
              state_d        = other_turn(state_q);
              timer_load     = 1'b1;
            end
          end

          WAIT_DROP: begin
            if (bus.drop_ack) begin
              drop_req_d = 1'b0;
              if (bus.drop_invalid) begin
                invalid_move_d = 1'b1;
                phase_d        = WAIT_MOVE;
                timer_load     = 1'b1;
              end else begin
                move_count_d = move_count_inc(move_count_q, CELLS_LIMIT);
                check_req_d  = 1'b1;
                phase_d      = WAIT_CHECK;
              end
            end
          end

          WAIT_CHECK: begin
            if (bus.check_done) begin
              check_req_d = 1'b0;
              phase_d     = WAIT_MOVE;
              if (bus.check_win) begin
                winner_d = winner_for(player_q);
                state_d  = END_GAME;
              end else if (move_count_q == CELLS_LIMIT) begin
                winner_d = WINNER_DRAW;
                state_d  = END_GAME;
              end else begin
                state_d    = other_turn(state_q);
                timer_load = 1'b1;
              end
            end
          end

          default: begin
            phase_d = WAIT_MOVE;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= GAME_INIT;
      phase_q        <= WAIT_MOVE;
      winner_q       <= WINNER_NONE;
      move_count_q   <= '0;
      column_q       <= '0;
      player_q       <= PLAYER_1;
      drop_req_q     <= 1'b0;
      check_req_q    <= 1'b0;
      invalid_move_q <= 1'b0;
      turn_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      winner_q       <= winner_d;
      move_count_q   <= move_count_d;
      column_q       <= column_d;
      player_q       <= player_d;
      drop_req_q     <= drop_req_d;
      check_req_q    <= check_req_d;
      invalid_move_q <= invalid_move_d;
      turn_timeout_q <= turn_timeout_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.winner       = winner_q;
  assign bus.move_count   = move_count_q;
  assign bus.drop_req     = drop_req_q;
  assign bus.drop_column  = column_q;
  assign bus.drop_player  = player_q;
  assign bus.check_req    = check_req_q;
  assign bus.invalid_move = invalid_move_q;
  assign bus.turn_timeout = turn_timeout_q;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: a vector table for the turn flow plus
// hand-written sequences for the full-board draw and reset mid-handshake.
module tb_turn_controller;

  typedef struct {
    string       name;
    logic        start;
    logic        p1v;
    logic [1:0]  p1c;
    logic        p2v;
    logic [1:0]  p2c;
    logic        ack;
    logic        inv;
    logic        done;
    logic        win;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  turn_controller_if bus ();

  turn_controller #(
    .TIMEOUT_CYCLES(8),
    .CELLS_NUMBER  (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Packed output view: state, winner, move_count, drop_req, drop_column,
  // drop_player, check_req, invalid_move, turn_timeout.
  function automatic logic [15:0] pk(int st, int wn, int mc, int dreq, int dcol,
                                     int dpl, int creq, int imv, int to);
    return {2'(st), 2'(wn), 5'(mc), 1'(dreq), 2'(dcol), 1'(dpl), 1'(creq),
            1'(imv), 1'(to)};
  endfunction

  function automatic string fmt(input logic [15:0] v);
    return $sformatf("st=%b wn=%b mc=%0d dreq=%b dcol=%0d dpl=%b creq=%b inv=%b to=%b",
                     v[15:14], v[13:12], v[11:7], v[6], v[5:4], v[3], v[2], v[1], v[0]);
  endfunction

  function automatic logic [15:0] outs();
    return {bus.state, bus.winner, bus.move_count, bus.drop_req, bus.drop_column,
            bus.drop_player, bus.check_req, bus.invalid_move, bus.turn_timeout};
  endfunction

  task automatic check(input string name, input logic [15:0] exp);
    logic [15:0] got;
    got = outs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %s, required %s", name, fmt(got), fmt(exp));
    end else begin
      $display("ok   %s: %s", name, fmt(got));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start        = 1'b0;
    bus.p1_valid     = 1'b0;
    bus.p1_column    = 2'd0;
    bus.p2_valid     = 1'b0;
    bus.p2_column    = 2'd0;
    bus.drop_ack     = 1'b0;
    bus.drop_invalid = 1'b0;
    bus.check_done   = 1'b0;
    bus.check_win    = 1'b0;
  endtask

  task automatic add(input string name, input int start, input int p1v, input int p1c,
                     input int p2v, input int p2c, input int ack, input int inv,
                     input int done, input int win, input logic [15:0] exp);
    vec_t v;
    v.name  = name;
    v.start = 1'(start);
    v.p1v   = 1'(p1v);
    v.p1c   = 2'(p1c);
    v.p2v   = 1'(p2v);
    v.p2c   = 2'(p2c);
    v.ack   = 1'(ack);
    v.inv   = 1'(inv);
    v.done  = 1'(done);
    v.win   = 1'(win);
    v.exp   = exp;
    vecs.push_back(v);
  endtask

  initial begin
    //   name             st p1v c p2v c ack inv dn win   st wn mc dq dc dp cq iv to
    add("init_idle",      0, 0,0, 0,0, 0,0, 0,0, pk(0,0,0, 0,0,0, 0,0,0));
    add("start",          1, 0,0, 0,0, 0,0, 0,0, pk(1,0,0, 0,0,0, 0,0,0));
    add("p1_req_c2",      0, 1,2, 0,0, 0,0, 0,0, pk(1,0,0, 1,2,0, 0,0,0));
    add("drop_req_hold",  0, 0,0, 0,0, 0,0, 0,0, pk(1,0,0, 1,2,0, 0,0,0));
    add("drop_ack_ok",    0, 0,0, 0,0, 1,0, 0,0, pk(1,0,1, 0,2,0, 1,0,0));
    add("check_nowin",    0, 0,0, 0,0, 0,0, 1,0, pk(2,0,1, 0,2,0, 0,0,0));
    add("p2turn_p1_ign",  0, 1,0, 0,0, 0,0, 0,0, pk(2,0,1, 0,2,0, 0,0,0));
    add("p2_req_c1",      0, 0,0, 1,1, 0,0, 0,0, pk(2,0,1, 1,1,1, 0,0,0));
    add("p2_ack_ok",      0, 0,0, 0,0, 1,0, 0,0, pk(2,0,2, 0,1,1, 1,0,0));
    add("p2_check_nowin", 0, 0,0, 0,0, 0,0, 1,0, pk(1,0,2, 0,1,1, 0,0,0));
    add("both_req",       0, 1,1, 1,3, 0,0, 0,0, pk(1,0,2, 1,1,0, 0,0,0));
    add("drop_invalid",   0, 0,0, 0,0, 1,1, 0,0, pk(1,0,2, 0,1,0, 0,1,0));
    add("invalid_clear",  0, 0,0, 0,0, 0,0, 0,0, pk(1,0,2, 0,1,0, 0,0,0));
    add("stray_done",     0, 0,0, 0,0, 0,0, 1,1, pk(1,0,2, 0,1,0, 0,0,0));
    add("p1_retry_c3",    0, 1,3, 0,0, 0,0, 0,0, pk(1,0,2, 1,3,0, 0,0,0));
    add("done_in_drop",   0, 0,0, 0,0, 0,0, 1,0, pk(1,0,2, 1,3,0, 0,0,0));
    add("retry_ack_ok",   0, 0,0, 0,0, 1,0, 0,0, pk(1,0,3, 0,3,0, 1,0,0));
    add("ack_in_check",   0, 0,0, 0,0, 1,1, 0,0, pk(1,0,3, 0,3,0, 1,0,0));
    add("check_win_p1",   0, 0,0, 0,0, 0,0, 1,1, pk(3,1,3, 0,3,0, 0,0,0));
    add("end_hold",       0, 0,0, 0,0, 0,0, 0,0, pk(3,1,3, 0,3,0, 0,0,0));
    add("end_start",      1, 0,0, 0,0, 0,0, 0,0, pk(0,0,0, 0,3,0, 0,0,0));
    add("init_start",     1, 0,0, 0,0, 0,0, 0,0, pk(1,0,0, 0,3,0, 0,0,0));
    for (int i = 1; i <= 7; i++) begin
      add($sformatf("tmo_wait_%0d", i), 0, 0, 0, (i == 3) ? 1 : 0, 2, 0, 0, 0, 0,
          pk(1,0,0, 0,3,0, 0,0,0));
    end
    add("tmo_expire",     0, 0,0, 0,0, 0,0, 0,0, pk(2,0,0, 0,3,0, 0,0,1));
    add("tmo_pulse_end",  0, 0,0, 0,0, 0,0, 0,0, pk(2,0,0, 0,3,0, 0,0,0));

    idle_inputs();
    reset = 1'b1;
    #1;
    check("reset_state", pk(0,0,0, 0,0,0, 0,0,0));
    tick();
    tick();
    reset = 1'b0;

    foreach (vecs[k]) begin
      bus.start        = vecs[k].start;
      bus.p1_valid     = vecs[k].p1v;
      bus.p1_column    = vecs[k].p1c;
      bus.p2_valid     = vecs[k].p2v;
      bus.p2_column    = vecs[k].p2c;
      bus.drop_ack     = vecs[k].ack;
      bus.drop_invalid = vecs[k].inv;
      bus.check_done   = vecs[k].done;
      bus.check_win    = vecs[k].win;
      tick();
      check(vecs[k].name, vecs[k].exp);
    end
    idle_inputs();

    // Full board: P2 opens after the timeout, sixteen moves, no winner.
    for (int i = 0; i < 16; i++) begin
      int pl;
      int st;
      int nx;
      pl = (i % 2 == 0) ? 1 : 0;
      st = (pl == 1) ? 2 : 1;
      nx = (pl == 1) ? 1 : 2;
      if (pl == 1) begin
        bus.p2_valid  = 1'b1;
        bus.p2_column = 2'(i % 4);
      end else begin
        bus.p1_valid  = 1'b1;
        bus.p1_column = 2'(i % 4);
      end
      tick();
      idle_inputs();
      check($sformatf("draw_req_%0d", i), pk(st,0,i, 1,i%4,pl, 0,0,0));
      bus.drop_ack = 1'b1;
      tick();
      idle_inputs();
      check($sformatf("draw_ack_%0d", i), pk(st,0,i+1, 0,i%4,pl, 1,0,0));
      bus.check_done = 1'b1;
      tick();
      idle_inputs();
      if (i < 15) begin
        check($sformatf("draw_chk_%0d", i), pk(nx,0,i+1, 0,i%4,pl, 0,0,0));
      end else begin
        check("draw_declared", pk(3,3,16, 0,3,0, 0,0,0));
      end
    end
    bus.start = 1'b1;
    tick();
    check("draw_to_init", pk(0,0,0, 0,3,0, 0,0,0));
    tick();
    bus.start = 1'b0;
    check("new_game", pk(1,0,0, 0,3,0, 0,0,0));

    // Asynchronous reset in the middle of a drop handshake.
    bus.p1_valid  = 1'b1;
    bus.p1_column = 2'd2;
    tick();
    idle_inputs();
    check("pre_reset_req", pk(1,0,0, 1,2,0, 0,0,0));
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", pk(0,0,0, 0,0,0, 0,0,0));
    #4;
    reset = 1'b0;
    bus.drop_ack = 1'b1;
    tick();
    idle_inputs();
    check("late_ack", pk(0,0,0, 0,0,0, 0,0,0));
    tick();
    check("after_late_ack", pk(0,0,0, 0,0,0, 0,0,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/turn_controller.md
Name: turn_controller

Overview:
- Game sequencer for the 4x4 Connect4 board.
- Owns the 2-bit game state (GAME_INIT/P1_TURN/P2_TURN/END_GAME) that the board datapath consumes.
- Arbitrates the two players' column requests so that only the current player's request is accepted, and forwards it to the board as a drop request with a handshake.
- Triggers the win checker after each placed token, tracks the move count, enforces a per-turn timeout, and declares the winner or a draw.

Parameters:
- TIMEOUT_CYCLES, 1000: clock cycles a player has in WAIT_MOVE before forfeiting the turn; must be >= 2.
- CELLS_NUMBER, 16: board cells; a draw is declared when move_count reaches this value.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  level; sampled in GAME_INIT and END_GAME only.
- p1_valid  in  1  player 1 column request valid.
- p1_column  in  2  player 1 column, 0-3.
- p2_valid  in  1  player 2 column request valid.
- p2_column  in  2  player 2 column, 0-3.
- drop_req  out  1  drop request to board; held high until drop_ack.
- drop_column  out  2  column of the pending drop; stable while drop_req is high.
- drop_player  out  1  0 = P1, 1 = P2; stable while drop_req is high.
- drop_ack  in  1  board finished the drop; one-cycle pulse.
- drop_invalid  in  1  column full; valid only when drop_ack = 1.
- check_req  out  1  win-check request; held high until check_done.
- check_done  in  1  win checker result ready; one-cycle pulse.
- check_win  in  1  1 = player who just dropped has four in a row; valid only when check_done = 1.
- state  out  2  00 GAME_INIT, 01 P1_TURN, 10 P2_TURN, 11 END_GAME.
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw.
- move_count  out  5  tokens placed this game, 0-16.
- invalid_move  out  1  one-cycle pulse: rejected drop.
- turn_timeout  out  1  one-cycle pulse: turn forfeited.

Behaviour:
- Reset values (asynchronous, takes effect immediately, including mid-handshake): state = GAME_INIT, phase = WAIT_MOVE, winner = 00, move_count = 0, all pulses and requests = 0, timeout counter = 0, latched column/player = 0.
- State changes only occur as listed below.
- GAME_INIT: move_count = 0, winner = 00. When start = 1, go to P1_TURN/WAIT_MOVE next cycle.
- END_GAME: outputs hold. When start = 1, go to GAME_INIT; a new game needs a second start.
- Turn phases inside P1_TURN/P2_TURN: WAIT_MOVE -> WAIT_DROP -> WAIT_CHECK.
- WAIT_MOVE:
  - Only the current player's valid is observed; the other player's valid/column is ignored, including when both are asserted in the same cycle.
  - On accept: latch column and player, assert drop_req the next cycle (latency 1), go to WAIT_DROP.
  - Timeout counter increments every cycle. At TIMEOUT_CYCLES-1 without a request: pulse turn_timeout, state swaps to the other player, counter clears; move_count is unchanged.
- WAIT_DROP: drop_req stays high until the cycle drop_ack = 1; it is deasserted the following cycle.
  - drop_invalid = 1: pulse invalid_move, same player, return to WAIT_MOVE, timeout counter restarts at 0.
  - drop_invalid = 0: move_count +1, assert check_req next cycle, go to WAIT_CHECK.
- WAIT_CHECK: check_req is held until check_done = 1.
  - check_win = 1: winner = 01 or 10 for the current player, state = END_GAME.
  - Else if move_count == CELLS_NUMBER: winner = 11, state = END_GAME.
  - Else: swap player, WAIT_MOVE, timeout counter cleared.
- drop_ack or check_done outside its matching phase is ignored.
- start during a turn is ignored.
- move_count saturates at 16 and never wraps.
- Timeout counter width is $clog2(TIMEOUT_CYCLES); it is cleared on every phase entry to WAIT_MOVE.

Decomposition:
- Shared package connect4_pkg:
  - State encodings GAME_INIT/P1_TURN/P2_TURN/END_GAME.
  - Winner codes NONE/P1/P2/DRAW.
  - CELLS_NUMBER and the player encoding (0 = P1, 1 = P2).
- One sub-module, turn_timer: loadable down-counter with clear and expire pulse, parameterised by TIMEOUT_CYCLES.
- The phase FSM and handshakes stay in turn_controller.

Test Plan:
- Reset, start = 1 for 1 cycle -> state = 01; p1_valid with column 2 -> drop_req = 1, drop_column = 2, drop_player = 0 next cycle; drop_ack with no invalid -> move_count = 1, check_req = 1; check_done with no win -> state = 10.
- In P1_TURN, p1_valid and p2_valid in the same cycle with columns 1 and 3 -> drop_column = 1, drop_player = 0; p2 request has no effect.
- drop_ack with drop_invalid = 1 -> invalid_move pulses for 1 cycle, state stays 01, move_count unchanged, next p1 request accepted.
- TIMEOUT_CYCLES = 8, no request -> turn_timeout pulses on cycle 8 of WAIT_MOVE, state 01 -> 10, move_count unchanged.
- Play 16 valid moves with check_win = 0 -> after the 16th check_done: winner = 11, state = 11; start -> state = 00; start -> state = 01 with move_count = 0.
- Assert reset while drop_req = 1 -> drop_req = 0 and state = 00 immediately, without waiting for a clock edge; a late drop_ack after reset has no effect.
